// File: rtl/disk_block_dma_if.sv
`default_nettype none
// ============================================================================
//  Module      : disk_block_dma_if
//  Description : Bundle of the block-transfer sequencer's control, status and
//                memory/disk transfer-port signals.
//                slave  : view of the sequencer
//                          (control in, status and bus drive out)
//                master : view of the CPU decode and memories around it
//  Ports       : start/dir/abort/mem_base/dsk_base/len (control),
//                busy/done/words_done (status),
//                mem_addr/mem_wdata/mem_we/mem_rdata (main-memory port),
//                dsk_addr/dsk_wdata/dsk_we/dsk_rdata (disk port)
//  Revision    : 1.0  initial release
// ============================================================================
interface disk_block_dma_if #(
    parameter int MEM_AW = 16,
    parameter int DSK_AW = 15,
    parameter int DW     = 16
);
    logic              start;
    logic              dir;
    logic              abort;
    logic [MEM_AW-1:0] mem_base;
    logic [DSK_AW-1:0] dsk_base;
    logic [15:0]       len;
    logic              busy;
    logic              done;
    logic [15:0]       words_done;
    logic [MEM_AW-1:0] mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_we;
    logic [DW-1:0]     mem_rdata;
    logic [DSK_AW-1:0] dsk_addr;
    logic [DW-1:0]     dsk_wdata;
    logic              dsk_we;
    logic [DW-1:0]     dsk_rdata;

    modport slave (
        input  start, dir, abort, mem_base, dsk_base, len, mem_rdata, dsk_rdata,
        output busy, done, words_done, mem_addr, mem_wdata, mem_we,
               dsk_addr, dsk_wdata, dsk_we
    );

    modport master (
        output start, dir, abort, mem_base, dsk_base, len, mem_rdata, dsk_rdata,
        input  busy, done, words_done, mem_addr, mem_wdata, mem_we,
               dsk_addr, dsk_wdata, dsk_we
    );
endinterface
`default_nettype wire

// File: rtl/disk_block_dma.sv
`default_nettype none
// ============================================================================
//  Module      : disk_block_dma
//  Description : Block-transfer sequencer between main memory and disk.
//                Copies len consecutive words, one word at a time:
//                read source, wait RD_LAT cycles, write destination.
//                dir=0 copies memory->disk, dir=1 copies disk->memory.
//  Ports       : clk, rst (synchronous, active-high)
//                bus (disk_block_dma_if.slave): control inputs, busy/done/
//                words_done status, memory and disk transfer ports
//  Revision    : 1.0  initial release
// ============================================================================
module disk_block_dma #(
    parameter int MEM_AW = 16,
    parameter int DSK_AW = 15,
    parameter int DW     = 16,
    parameter int RD_LAT = 1     // legal range 1..4
) (
    input  logic                  clk,
    input  logic                  rst,
    disk_block_dma_if.slave       bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [2:0] C_WAIT_LAST = 3'(RD_LAT - 1);

    state_t            r_state;
    state_t            w_next;

    logic              r_dir;
    logic [MEM_AW-1:0] r_mem_base;
    logic [DSK_AW-1:0] r_dsk_base;
    logic [15:0]       r_len;
    logic [15:0]       r_words_done;
    logic [DW-1:0]     r_data;
    logic [2:0]        r_wait_cnt;

    logic              w_accept;
    logic              w_last_wait;
    logic              w_last_word;
    logic [MEM_AW-1:0] w_mem_ptr;
    logic [DSK_AW-1:0] w_dsk_ptr;

    logic              w_busy;
    logic              w_done;
    logic [MEM_AW-1:0] w_mem_addr;
    logic [DW-1:0]     w_mem_wdata;
    logic              w_mem_we;
    logic [DSK_AW-1:0] w_dsk_addr;
    logic [DW-1:0]     w_dsk_wdata;
    logic              w_dsk_we;

    // Start is only honoured in IDLE; while busy it has no effect at all.
    assign w_accept    = (r_state == S_IDLE) && bus.start;
    assign w_last_wait = (r_state == S_WAIT) && (r_wait_cnt == C_WAIT_LAST);
    assign w_last_word = ((r_words_done + 16'd1) == r_len);

    // Word pointers wrap naturally at the width of each address space.
    assign w_mem_ptr = r_mem_base + MEM_AW'(r_words_done);
    assign w_dsk_ptr = r_dsk_base + DSK_AW'(r_words_done);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and bus drive. Only the side being accessed in the
    // current state drives a non-zero address; everything else is 0.
    // ------------------------------------------------------------------
    always_comb begin
        w_next      = r_state;
        w_busy      = (r_state != S_IDLE);
        w_done      = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_mem_we    = 1'b0;
        w_dsk_addr  = '0;
        w_dsk_wdata = '0;
        w_dsk_we    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = (bus.len == 16'd0) ? S_DONE : S_READ;
                end
            end
            S_READ, S_WAIT: begin
                if (r_dir) begin
                    w_dsk_addr = w_dsk_ptr;
                end else begin
                    w_mem_addr = w_mem_ptr;
                end
                if (r_state == S_READ) begin
                    w_next = S_WAIT;
                end else if (w_last_wait) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (r_dir) begin
                    w_mem_addr  = w_mem_ptr;
                    w_mem_wdata = r_data;
                    w_mem_we    = 1'b1;
                end else begin
                    w_dsk_addr  = w_dsk_ptr;
                    w_dsk_wdata = r_data;
                    w_dsk_we    = 1'b1;
                end
                w_next = w_last_word ? S_DONE : S_READ;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        // Abort overrides the sequence; a write already on the bus in this
        // cycle still lands because its enable is combinational.
        if (bus.abort && (r_state != S_IDLE)) begin
            w_next = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: transfer parameters, wait counter, data word, progress
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dir        <= 1'b0;
            r_mem_base   <= '0;
            r_dsk_base   <= '0;
            r_len        <= '0;
            r_words_done <= '0;
            r_data       <= '0;
            r_wait_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_dir        <= bus.dir;
                r_mem_base   <= bus.mem_base;
                r_dsk_base   <= bus.dsk_base;
                r_len        <= bus.len;
                r_words_done <= '0;
            end

            if (r_state == S_READ) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 3'd1;
            end

            // Source data is valid on the last WAIT cycle only.
            if (w_last_wait) begin
                r_data <= r_dir ? bus.dsk_rdata : bus.mem_rdata;
            end

            if (r_state == S_WRITE) begin
                r_words_done <= r_words_done + 16'd1;
            end
        end
    end

    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.words_done = r_words_done;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_wdata  = w_mem_wdata;
    assign bus.mem_we     = w_mem_we;
    assign bus.dsk_addr   = w_dsk_addr;
    assign bus.dsk_wdata  = w_dsk_wdata;
    assign bus.dsk_we     = w_dsk_we;

endmodule
`default_nettype wire
